// File: rtl/cla_adder_exerciser.sv
// Exhaustive stimulus driver and checker for a combinational WIDTH-bit adder.
// Sweeps every {A,B,Cin}, waits SETTLE_CYCLES per vector, compares against A+B+Cin.
module cla_adder_exerciser #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int STOP_ON_FAIL  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  output logic                 dut_cin,
  input  logic [WIDTH-1:0]     dut_sum,
  input  logic                 dut_cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_count,
  output logic [2*WIDTH+1:0]   vec_count,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b,
  output logic                 fail_cin,
  output logic                 fail_valid
);

  localparam int IW = 2 * WIDTH + 1;
  localparam int VW = 2 * WIDTH + 2;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [IW-1:0] IDX_ZERO    = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE     = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] IDX_LAST    = {IW{1'b1}};
  localparam logic [VW-1:0] VEC_ZERO    = {VW{1'b0}};
  localparam logic [VW-1:0] VEC_ONE     = {{(VW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic          STOP_EN     = (STOP_ON_FAIL != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [15:0]     err_q, err_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic [IW-1:0]   fail_idx_q, fail_idx_d;
  logic            fail_valid_q, fail_valid_d;

  logic [WIDTH:0]  expected_s;
  logic            mismatch_s;

  // The driven operands are slices of the registered vector index, so they only
  // move when the index register is loaded.
  assign dut_a      = idx_q[2*WIDTH:WIDTH+1];
  assign dut_b      = idx_q[WIDTH:1];
  assign dut_cin    = idx_q[0];
  assign busy       = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done       = done_q;
  assign pass       = done_q && (err_q == 16'd0);
  assign err_count  = err_q;
  assign vec_count  = vec_q;
  assign fail_a     = fail_idx_q[2*WIDTH:WIDTH+1];
  assign fail_b     = fail_idx_q[WIDTH:1];
  assign fail_cin   = fail_idx_q[0];
  assign fail_valid = fail_valid_q;

  assign expected_s = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
  assign mismatch_s = (expected_s != {dut_cout, dut_sum});

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= IDX_ZERO;
      cnt_q        <= CNT_ZERO;
      done_q       <= 1'b0;
      err_q        <= 16'd0;
      vec_q        <= VEC_ZERO;
      fail_idx_q   <= IDX_ZERO;
      fail_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      vec_q        <= vec_d;
      fail_idx_q   <= fail_idx_d;
      fail_valid_q <= fail_valid_d;
    end
  end

  // Sweep sequencing, result accumulation and first-failure capture.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    done_d       = done_q;
    err_d        = err_q;
    vec_d        = vec_q;
    fail_idx_d   = fail_idx_q;
    fail_valid_d = fail_valid_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_SETTLE;
          idx_d        = IDX_ZERO;
          cnt_d        = CNT_ZERO;
          done_d       = 1'b0;
          err_d        = 16'd0;
          vec_d        = VEC_ZERO;
          fail_idx_d   = IDX_ZERO;
          fail_valid_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_CHECK: begin
        vec_d = vec_q + VEC_ONE;
        if (mismatch_s) begin
          if (err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
          end else begin
            err_d = err_q;
          end
          if (!fail_valid_q) begin
            fail_idx_d   = idx_q;
            fail_valid_d = 1'b1;
          end else begin
            fail_idx_d = fail_idx_q;
          end
        end else begin
          err_d = err_q;
        end
        // On termination the index is left alone so the operands hold the last vector.
        if ((idx_q == IDX_LAST) || (STOP_EN && mismatch_s)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          cnt_d   = CNT_ZERO;
          state_d = S_SETTLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cla_adder_exerciser.sv
// Bench for cla_adder_exerciser: two instances (full sweep / stop-on-fail) driving
// a behavioural adder with selectable faults, checked against a vector-level model.
module tb_cla_adder_exerciser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  int   mode0 = 0;
  int   mode1 = 0;
  bit   bad_tbl [512];

  int   n_tests = 0;
  int   n_fail  = 0;

  logic [3:0] dut_a0, dut_b0, dut_sum0, fail_a0, fail_b0;
  logic       dut_cin0, dut_cout0, busy0, done0, pass0, fail_cin0, fail_valid0;
  logic [15:0] err0;
  logic [9:0]  vec0;

  logic [3:0] dut_a1, dut_b1, dut_sum1, fail_a1, fail_b1;
  logic       dut_cin1, dut_cout1, busy1, done1, pass1, fail_cin1, fail_valid1;
  logic [15:0] err1;
  logic [9:0]  vec1;

  always #5 clk = ~clk;

  // Adder under test with an injectable fault.
  function automatic logic [4:0] faulty_add(input int mode, input logic [3:0] a,
                                            input logic [3:0] b, input logic c);
    logic [4:0] r;
    r = {1'b0, a} + {1'b0, b} + {4'b0000, c};
    case (mode)
      1: r[0] = 1'b0;
      2: r[4] = ~r[4];
      3: if (bad_tbl[{a, b, c}]) r[0] = ~r[0];
      default: ;
    endcase
    return r;
  endfunction

  assign {dut_cout0, dut_sum0} = faulty_add(mode0, dut_a0, dut_b0, dut_cin0);
  assign {dut_cout1, dut_sum1} = faulty_add(mode1, dut_a1, dut_b1, dut_cin1);

  cla_adder_exerciser #(.WIDTH(4), .SETTLE_CYCLES(2), .STOP_ON_FAIL(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .dut_a(dut_a0), .dut_b(dut_b0), .dut_cin(dut_cin0),
    .dut_sum(dut_sum0), .dut_cout(dut_cout0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .vec_count(vec0),
    .fail_a(fail_a0), .fail_b(fail_b0), .fail_cin(fail_cin0), .fail_valid(fail_valid0)
  );

  cla_adder_exerciser #(.WIDTH(4), .SETTLE_CYCLES(1), .STOP_ON_FAIL(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .dut_a(dut_a1), .dut_b(dut_b1), .dut_cin(dut_cin1),
    .dut_sum(dut_sum1), .dut_cout(dut_cout1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .vec_count(vec1),
    .fail_a(fail_a1), .fail_b(fail_b1), .fail_cin(fail_cin1), .fail_valid(fail_valid1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_done(input int inst);
    return (inst == 0) ? done0 : done1;
  endfunction
  function automatic logic get_busy(input int inst);
    return (inst == 0) ? busy0 : busy1;
  endfunction
  function automatic int get_vec(input int inst);
    return (inst == 0) ? int'(vec0) : int'(vec1);
  endfunction
  function automatic int get_err(input int inst);
    return (inst == 0) ? int'(err0) : int'(err1);
  endfunction
  function automatic logic get_fv(input int inst);
    return (inst == 0) ? fail_valid0 : fail_valid1;
  endfunction
  function automatic int get_fail_idx(input int inst);
    return (inst == 0) ? int'({fail_a0, fail_b0, fail_cin0}) : int'({fail_a1, fail_b1, fail_cin1});
  endfunction

  // Reference: walk all 512 vectors with plain integer arithmetic.
  task automatic model(input int mode, output int errs, output int first);
    int a, b, c;
    logic [4:0] obs;
    errs  = 0;
    first = -1;
    for (int i = 0; i < 512; i++) begin
      a   = i / 32;
      b   = (i / 2) % 16;
      c   = i % 2;
      obs = faulty_add(mode, 4'(a), 4'(b), 1'(c));
      if (int'(obs) != a + b + c) begin
        errs++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic run_sweep(input int inst, input bit spurious, output int cycles);
    int prev_vec;
    int viol;
    @(negedge clk);
    if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    check_eq("start_busy", get_busy(inst), 1);
    check_eq("start_clear", {get_done(inst), get_fv(inst), 16'(get_err(inst)), 16'(get_vec(inst))}, 0);
    cycles   = 0;
    prev_vec = 0;
    viol     = 0;
    while (!get_done(inst) && cycles < 5000) begin
      if (spurious) begin
        if (inst == 0) start0 = ($urandom_range(0, 19) == 0);
        else           start1 = ($urandom_range(0, 19) == 0);
      end
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      cycles++;
      if (get_vec(inst) < prev_vec) viol++;
      if (get_vec(inst) > prev_vec + 1) viol++;
      prev_vec = get_vec(inst);
      if (!get_done(inst) && !get_busy(inst)) viol++;
    end
    check_eq("sweep_monotonic_busy", viol, 0);
    check_eq("busy_at_done", get_busy(inst), 0);
  endtask

  initial begin
    int cyc, errs, first;

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset0", {dut_a0, dut_b0, dut_cin0, busy0, done0, pass0, err0, vec0,
                        fail_a0, fail_b0, fail_cin0, fail_valid0}, 0);
    check_eq("reset1", {dut_a1, dut_b1, dut_cin1, busy1, done1, pass1, err1, vec1,
                        fail_a1, fail_b1, fail_cin1, fail_valid1}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Correct adder, full sweep.
    mode0 = 0;
    run_sweep(0, 1'b0, cyc);
    check_eq("good_cycles", cyc, 1536);
    check_eq("good_vec", vec0, 512);
    check_eq("good_err", err0, 0);
    check_eq("good_pass_fv", {done0, pass0, fail_valid0}, 3'b110);

    // Sum[0] stuck at 0.
    mode0 = 1;
    model(1, errs, first);
    run_sweep(0, 1'b0, cyc);
    check_eq("stuck_err", err0, 256);
    check_eq("stuck_err_model", err0, errs);
    check_eq("stuck_pass_fv", {pass0, fail_valid0}, 2'b01);
    check_eq("stuck_first", {fail_a0, fail_b0, fail_cin0}, 9'd1);

    // Cout inverted; starting from DONE with nonzero counters.
    mode0 = 2;
    run_sweep(0, 1'b0, cyc);
    check_eq("cinv_err", err0, 512);
    check_eq("cinv_first", {fail_valid0, fail_a0, fail_b0, fail_cin0}, 10'h200);
    check_eq("cinv_vec", vec0, 512);

    // Random sparse faults with spurious starts while busy.
    for (int i = 0; i < 512; i++) bad_tbl[i] = ($urandom_range(0, 63) == 0);
    mode0 = 3;
    model(3, errs, first);
    run_sweep(0, 1'b1, cyc);
    check_eq("rand_cycles", cyc, 1536);
    check_eq("rand_vec", vec0, 512);
    check_eq("rand_err", err0, errs);
    check_eq("rand_pass", pass0, (errs == 0));
    check_eq("rand_fv", fail_valid0, (errs > 0));
    if (errs > 0) check_eq("rand_first", get_fail_idx(0), first);

    // Reset in the middle of a sweep.
    mode0 = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (699) @(posedge clk);
    #1;
    check_eq("mid_vec", vec0, 233);
    rst = 1'b1;
    #1;
    check_eq("mid_reset", {dut_a0, dut_b0, dut_cin0, busy0, done0, pass0, err0, vec0,
                           fail_a0, fail_b0, fail_cin0, fail_valid0}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep(0, 1'b0, cyc);
    check_eq("after_reset", {16'(cyc), 10'(vec0), err0, pass0}, {16'd1536, 10'd512, 16'd0, 1'b1});

    // Stop-on-fail instance with Sum[0] stuck.
    mode1 = 1;
    run_sweep(1, 1'b0, cyc);
    check_eq("stop_cycles", cyc, 4);
    check_eq("stop_vec_err", {vec1, err1}, {10'd2, 16'd1});
    check_eq("stop_held", {dut_a1, dut_b1, dut_cin1}, 9'd1);
    check_eq("stop_flags", {done1, pass1, fail_valid1, fail_cin1}, 4'b1011);

    // Stop-on-fail with random faults.
    mode1 = 3;
    model(3, errs, first);
    run_sweep(1, 1'b1, cyc);
    if (errs > 0) begin
      check_eq("rstop_cycles", cyc, 2 * (first + 1));
      check_eq("rstop_vec", vec1, first + 1);
      check_eq("rstop_held", {dut_a1, dut_b1, dut_cin1}, first);
      check_eq("rstop_err", err1, 1);
    end else begin
      check_eq("rstop_cycles", cyc, 1024);
      check_eq("rstop_vec", vec1, 512);
    end

    // Stop-on-fail instance with a correct adder runs to the end.
    mode1 = 0;
    run_sweep(1, 1'b0, cyc);
    check_eq("stop_good", {16'(cyc), 10'(vec1), err1, pass1}, {16'd1024, 10'd512, 16'd0, 1'b1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_adder_exerciser.md
Name: cla_adder_exerciser

Overview:
Self-checking hardware stimulus driver and result checker for a combinational WIDTH-bit carry look-ahead adder. It drives the adder's A/B/Cin inputs and reads back its Sum/Cout outputs. On start it sweeps every {A,B,Cin} combination exhaustively. It waits a programmable settle time per vector, compares against an internal golden A+B+Cin and accumulates pass/fail status. It is used for on-silicon/FPGA bring-up of the adder and as a reusable bench component.

Parameters:
WIDTH, 4, operand width of the adder under test (1..8).
SETTLE_CYCLES, 2, clock cycles a vector is held before sampling (>=1).
STOP_ON_FAIL, 0, 1 = halt the sweep at the first mismatch; 0 = complete the full sweep.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  begin a sweep; sampled only in IDLE or DONE.
dut_a  output  WIDTH  operand A to the adder (registered).
dut_b  output  WIDTH  operand B to the adder (registered).
dut_cin  output  1  carry-in to the adder (registered).
dut_sum  input  WIDTH  Sum from the adder.
dut_cout  input  1  Cout from the adder.
busy  output  1  sweep in progress.
done  output  1  sweep finished; held until the next start or reset.
pass  output  1  done && err_count==0.
err_count  output  16  mismatching vectors, saturates at 16'hFFFF.
vec_count  output  2*WIDTH+2  vectors checked in the current/last sweep.
fail_a, fail_b  output  WIDTH  A/B of the first failing vector.
fail_cin  output  1  Cin of the first failing vector.
fail_valid  output  1  fail_* fields hold a captured failure.

Behaviour:
- Reset (async, any state): state=IDLE. All outputs are 0, including dut_*, busy, done, pass, counters and fail_* fields.
- Vector index i is 2*WIDTH+1 bits wide and runs 0..2^(2*WIDTH+1)-1. The mapping is dut_a=i[2W:W+1], dut_b=i[W:1], dut_cin=i[0]. For W=4 there are 512 vectors.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE with start=1, at that edge:
  - i<=0 and dut_* <= vector 0.
  - err_count, vec_count, fail_* cleared; done<=0.
  - settle counter <=0; state<=SETTLE.
- SETTLE: the counter increments each cycle. When it reaches SETTLE_CYCLES-1, state<=CHECK.
- CHECK (one cycle): compute expected = dut_a + dut_b + dut_cin at WIDTH+1 bits, and compare it with {dut_cout,dut_sum}.
  - vec_count increments.
  - On mismatch: err_count increments (saturating). If fail_valid=0, the current dut_* values are captured into fail_* and fail_valid<=1.
  - If i is the last index, or (STOP_ON_FAIL && mismatch): state<=DONE, done<=1, and dut_* hold their last value.
  - Otherwise: i<=i+1, dut_* <= next vector, settle counter <=0, state<=SETTLE.
- Throughput: SETTLE_CYCLES+1 cycles per vector. A full sweep for W=4, SETTLE=2 asserts done 1536 cycles after the start edge.
- busy=1 exactly in SETTLE and CHECK. start is ignored while busy.
- pass is combinational from done and err_count. pass=0 whenever done=0.
- Reset mid-sweep aborts immediately to the reset values. A subsequent start runs a clean sweep.
- dut_* change only at the IDLE/DONE->SETTLE edge and the CHECK->SETTLE edge. They never change while being sampled.

Test Plan:
- Correct adder model, W=4, SETTLE=2, pulse start -> busy 1535 cycles, done at cycle 1536, vec_count=512, err_count=0, pass=1, fail_valid=0.
- Adder with Sum[0] stuck at 0 -> err_count=256, pass=0, fail_valid=1, fail_a=0, fail_b=0, fail_cin=1.
- Adder with Cout inverted -> err_count=512, first failure captured as a=0, b=0, cin=0.
- STOP_ON_FAIL=1 with the Sum[0] stuck fault -> done after vector index 1, vec_count=2, err_count=1, dut_a=0, dut_b=0, dut_cin=1 held.
- Assert rst at cycle 700 of a sweep -> all outputs 0 and state IDLE next. A new start completes a clean sweep with vec_count=512.
- Pulse start repeatedly while busy -> no restart and vec_count monotonic. Start in DONE -> counters cleared, new sweep begins.
